data_memory_responder: RTL

Multi-cycle responder for the processor's data-memory load/store interface. It accepts a read or write request from the datapath (`Address`, `WriteData`, `MemRead`, `MemWrite`), holds it for a fixed access latency, and then completes it with a one-cycle `Ready` pulse. Read data is returned on `ReadData` during that pulse. It is the memory side of the datapath-to-DM interface and replaces the zero-latency data memory when the controller runs stalling loads and stores. Storage is a word-addressed RAM inside the block.

---
 rtl/data_memory_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts a load/store, waits LATENCY cycles, then
// completes with a one-cycle Ready pulse. Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses.
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        Error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    is_write_q;
    logic                    conflict_q;
    logic                    misalign_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    error_q;
    logic [31:0]             rdata_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    req_s;
    logic                    done_s;
    logic                    ram_we_s;
    logic                    misalign_d;
    logic                    unused_addr_s;

    assign req_s         = MemRead | MemWrite;
    assign done_s        = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // A synchronous reset on the commit edge discards the pending write.
    assign ram_we_s      = done_s && is_write_q && !misalign_q && !Rst;
    assign unused_addr_s = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_d = (Address[1:0] != 2'b00);
`else
    assign misalign_d = 1'b0;
`endif

    // Word RAM write port; contents survive reset.
    always_ff @(posedge Clk) begin
        if (ram_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Request FSM: latch at acceptance, count down, complete, then wait for strobes to drop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            conflict_q <= 1'b0;
            misalign_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    if (req_s) begin
                        idx_q      <= Address[DEPTH_LOG2+1:2];
                        wdata_q    <= WriteData;
                        is_write_q <= MemWrite;
                        conflict_q <= MemRead & MemWrite;
                        misalign_q <= misalign_d;
                        cnt_q      <= CNT_LOAD;
                        busy_q     <= 1'b1;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        ready_q <= 1'b1;
                        error_q <= conflict_q | misalign_q;
                        busy_q  <= 1'b0;
                        if (misalign_q) begin
                            rdata_q <= 32'd0;
                        end else if (!is_write_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    if (!req_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign Error    = error_q;

endmodule
